multi_digit_seven_seg_scan: RTL and testbench

Parametrised multi-digit seven-segment driver, the successor to the two-digit static decoder. It accepts a binary value through a load/ready handshake and converts it to BCD with a sequential shift-and-add-3 engine. It then time-multiplexes the digits onto one shared segment bus with a one-hot digit enable. It sits between the datapath result registers and the board display pins, replacing the per-digit decoders.

---
 rtl/seven_seg_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/multi_digit_seven_seg_scan.sv | 108 ++++++++++
 tb/tb_multi_digit_seven_seg_scan.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment patterns, BCD-to-segment decode and converter FSM states
// for the scanned multi-digit seven-segment display.
package seven_seg_pkg;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'b011_1111;
  localparam logic [6:0] SEG_1     = 7'b000_0110;
  localparam logic [6:0] SEG_2     = 7'b101_1011;
  localparam logic [6:0] SEG_3     = 7'b100_1111;
  localparam logic [6:0] SEG_4     = 7'b110_0110;
  localparam logic [6:0] SEG_5     = 7'b110_1101;
  localparam logic [6:0] SEG_6     = 7'b111_1101;
  localparam logic [6:0] SEG_7     = 7'b000_0111;
  localparam logic [6:0] SEG_8     = 7'b111_1111;
  localparam logic [6:0] SEG_9     = 7'b110_1111;
  localparam logic [6:0] SEG_DASH  = 7'b100_0000;
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Elaboration-time 10^n, used for the overflow threshold.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one bit per clock,
// WIDTH iterations, then a single DONE cycle that commits bcd/ovf together.
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int RW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  conv_state_e       state_q;
  logic [RW-1:0]     work_q, work_d;
  logic [CW-1:0]     cnt_q;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BW-1:0]     bcd_q;
  logic              ovf_q;

  // One double-dabble step: correct every BCD nibble >= 5, then shift in the next bit.
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_d[WIDTH+4*i +: 4] >= 4'd5)
        work_d[WIDTH+4*i +: 4] = work_d[WIDTH+4*i +: 4] + 4'd3;
    end
    work_d = work_d << 1;
  end

  always_comb begin
    ovf_pend_d = ({{(64-WIDTH){1'b0}}, value} > MAX_VAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            work_q     <= {{BW{1'b0}}, value};
            cnt_q      <= '0;
            ovf_pend_q <= ovf_pend_d;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: begin
          bcd_q   <= ovf_pend_q ? {DIGITS{4'h9}} : work_q[RW-1 -: BW];
          ovf_q   <= ovf_pend_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/multi_digit_seven_seg_scan.sv
// Multi-digit scanned seven-segment driver: load/ready front end into the BCD
// converter, free-running digit scan, registered seg/an. Option: LZ_BLANK_EN.
module multi_digit_seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              conv_busy, conv_done;
  logic              start;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [DIGITS-1:0] blank_mask;
  logic [3:0]        cur_code;
  logic              cur_blank;

  assign ready = !conv_busy && !conv_done;
  assign start = load && ready;

  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd_out),
    .ovf   (overflow)
  );

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Digit 0 is never blanked so a zero value still shows a single "0".
  always_comb begin
    blank_mask = '0;
`ifdef LZ_BLANK_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (bcd_out[4*i +: 4] != 4'd0) seen = 1'b1;
        blank_mask[i] = !seen && !overflow;
      end
    end
`endif
  end

  always_comb begin
    cur_code  = 4'd0;
    cur_blank = 1'b0;
    an_d      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = (idx_q == IW'(i));
      if (idx_q == IW'(i)) begin
        cur_code  = bcd_out[4*i +: 4];
        cur_blank = blank_mask[i];
      end
    end
    if (overflow)       seg_d = SEG_DASH;
    else if (cur_blank) seg_d = SEG_BLANK;
    else                seg_d = seg_decode(cur_code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      an_q    <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_multi_digit_seven_seg_scan.sv
// Randomized self-checking bench for multi_digit_seven_seg_scan (DIGITS=4,
// WIDTH=14, SCAN_DIV=4) against an arithmetic display model.
module tb_multi_digit_seven_seg_scan;

  localparam int D  = 4;
  localparam int W  = 14;
  localparam int SD = 4;

  logic            clk;
  logic            rst_n;
  logic            load;
  logic [W-1:0]    value;
  logic            ready;
  logic [4*D-1:0]  bcd_out;
  logic            overflow;
  logic [6:0]      seg;
  logic [D-1:0]    an;

  int n_tests = 0;
  int n_fail  = 0;
  int k;              // rising edges since reset release
  int m_val = 0;      // value the display should currently hold
  bit m_ovf = 0;

  logic [6:0] seg_tab [10] = '{7'b011_1111, 7'b000_0110, 7'b101_1011, 7'b100_1111,
                               7'b110_0110, 7'b110_1101, 7'b111_1101, 7'b000_0111,
                               7'b111_1111, 7'b110_1111};

  multi_digit_seven_seg_scan #(.DIGITS(D), .WIDTH(W), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .ready    (ready),
    .bcd_out  (bcd_out),
    .overflow (overflow),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else        k <= k + 1;

  function automatic int p10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r = '0;
    if (v > 9999) return 16'h9999;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] model_seg(input int v, input bit ov, input int dig);
    if (ov) return 7'b100_0000;
`ifdef LZ_BLANK_EN
    if (dig > 0 && v < p10(dig)) return 7'b000_0000;
`endif
    return seg_tab[(v / p10(dig)) % 10];
  endfunction

  function automatic logic [D-1:0] model_an(input int edges);
    logic [D-1:0] a = '0;
    a[((edges - 1) / SD) % D] = 1'b1;
    return a;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a load and wait for ready; reports the number of ready-low samples.
  task automatic do_load(input int v, input string name, output int lat);
    int   guard = 0;
    bit   held = 1;
    lat = 0;
    while (ready !== 1'b1 && guard < 100) begin tick; guard++; end
    load = 1'b1; value = W'(v);
    tick;
    load = 1'b0;
    while (ready !== 1'b1 && lat < 100) begin
      if (bcd_out !== model_bcd(m_ovf ? 10000 : m_val)) held = 0;
      lat++;
      tick;
    end
    n_tests++;
    if (lat >= 100) begin
      n_fail++; $display("FAIL %s timeout: ready never returned", name);
    end
    n_tests++;
    if (!held) begin
      n_fail++; $display("FAIL %s hold: bcd_out changed during conversion", name);
    end
    m_val = v; m_ovf = (v > 9999);
  endtask

  task automatic check_result(input string name);
    n_tests++;
    if (bcd_out !== model_bcd(m_val) || overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL %s result: bcd_out=%h ovf=%0b expected %h ovf=%0b",
               name, bcd_out, overflow, model_bcd(m_val), m_ovf);
    end
  endtask

  // One full frame: an must follow the slot schedule, seg must match the model.
  task automatic check_frame(input string name);
    int bad = 0;
    tick;
    for (int j = 0; j < D * SD; j++) begin
      logic [D-1:0] ea;
      int dig;
      ea  = model_an(k);
      dig = ((k - 1) / SD) % D;
      n_tests++;
      if (an !== ea || seg !== model_seg(m_val, m_ovf, dig)) begin
        n_fail++;
        if (bad < 4)
          $display("FAIL %s frame: k=%0d an=%b seg=%b expected an=%b seg=%b",
                   name, k, an, seg, ea, model_seg(m_val, m_ovf, dig));
        bad++;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ready !== 1'b1 || bcd_out !== '0 || overflow !== 1'b0 || seg !== '0 || an !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b bcd=%h ovf=%b seg=%b an=%b expected 1 0000 0 0 0",
               ready, bcd_out, overflow, seg, an);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    tick;
    n_tests++;
    if (an !== 4'b0001 || seg !== 7'b011_1111) begin
      n_fail++;
      $display("FAIL reset_first: an=%b seg=%b expected 0001 0111111", an, seg);
    end
    for (int j = 0; j < 12; j++) begin
      tick;
      n_tests++;
      if (an !== model_an(k)) begin
        n_fail++; $display("FAIL reset_rotate: k=%0d an=%b expected %b", k, an, model_an(k));
      end
    end
  endtask

  task automatic test_load_1234;
    int lat;
    do_load(1234, "load1234", lat);
    n_tests++;
    if (lat != W + 1) begin
      n_fail++; $display("FAIL load1234 latency: %0d expected %0d", lat, W + 1);
    end
    check_result("load1234");
    check_frame("load1234");
  endtask

  task automatic test_overflow;
    int lat;
    do_load(10000, "ovf10000", lat);
    check_result("ovf10000");
    check_frame("ovf10000");
    do_load(7, "after_ovf7", lat);
    check_result("after_ovf7");
    check_frame("after_ovf7");
  endtask

  task automatic test_random;
    int lat;
    int vals[10];
    vals[0] = 9999; vals[1] = 0;
    for (int i = 2; i < 10; i++) vals[i] = $urandom_range(0, 16383);
    for (int i = 0; i < 10; i++) begin
      do_load(vals[i], "random", lat);
      n_tests++;
      if (lat != W + 1) begin
        n_fail++; $display("FAIL random latency: v=%0d %0d expected %0d", vals[i], lat, W + 1);
      end
      check_result("random");
      if (i < 4) check_frame("random");
    end
  endtask

  task automatic test_lz;
    int lat;
    do_load(0, "lz0", lat);
    check_result("lz0");
    check_frame("lz0");
    do_load(45, "lz45", lat);
    check_result("lz45");
    check_frame("lz45");
  endtask

  task automatic test_load_while_busy;
    int lat = 0;
    load = 1'b1; value = W'(9999);
    tick;
    value = W'(1111);
    while (ready !== 1'b1 && lat < 100) begin lat++; tick; end
    load = 1'b0;
    m_val = 9999; m_ovf = 0;
    n_tests++;
    if (lat != W + 1) begin
      n_fail++; $display("FAIL busy_load latency: %0d expected %0d", lat, W + 1);
    end
    check_result("busy_load");
    repeat (3) tick;
    n_tests++;
    if (ready !== 1'b1 || bcd_out !== 16'h9999) begin
      n_fail++; $display("FAIL busy_load ignored: ready=%b bcd=%h expected 1 9999", ready, bcd_out);
    end
  endtask

  task automatic test_reset_mid;
    load = 1'b1; value = W'(8888);
    tick;
    load = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bcd_out !== '0 || ready !== 1'b1 || overflow !== 1'b0 || an !== '0 || seg !== '0) begin
      n_fail++;
      $display("FAIL reset_mid during: bcd=%h ready=%b ovf=%b an=%b seg=%b expected 0000 1 0 0 0",
               bcd_out, ready, overflow, an, seg);
    end
    tick;
    rst_n = 1'b1;
    m_val = 0; m_ovf = 0;
    repeat (20) tick;
    n_tests++;
    if (bcd_out !== '0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid after: bcd=%h ready=%b expected 0000 1", bcd_out, ready);
    end
    check_frame("reset_mid");
  endtask

  initial begin
    test_reset;
    test_load_1234;
    test_overflow;
    test_random;
    test_lz;
    test_load_while_busy;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
